mmio_timer: RTL and testbench

MMIO_TIMER -- requirements
Module: mmio_timer

---
 rtl/mmio_timer.sv | 187 ++++++++++++++++++
 tb/tb_mmio_timer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// Purpose : memory-mapped down-counting timer with prescaler, reload and sticky expiry interrupt.
// Latency : register writes take effect on the edge they are sampled; read data appears one cycle after sel&re.
// Backpress: none -- the bus slave is always ready; every access completes in a single cycle.
//
// Ports:
//   clk    - system clock, all state updates on its rising edge
//   reset  - synchronous active-low reset
//   sel    - bus address-decode select
//   addr   - word offset: 0=CTRL, 1=LOAD, 2=COUNT, 3=STATUS
//   wdata  - CPU write data
//   we     - CPU byte write enables; only a full-word write (4'b1111) is honoured
//   re     - CPU read strobe
//   rdata  - read data, valid the cycle after a sel&re cycle, 0 otherwise
//   irq    - level interrupt, EXP & IRQ_EN, driven from registered state only
module mmio_timer #(
  parameter int unsigned PRESCALE = 12000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LOAD   = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // PRESCALE is at most 2^16, so its terminal value always fits 16 bits.
  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

  // CTRL field positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;

  // Architectural state
  logic [2:0]  ctrl_q;
  logic [31:0] load_q;
  logic [31:0] count_q;
  logic [15:0] presc_q;
  logic        exp_q;
  logic [31:0] rdata_q;
  logic        rd_pend_q;

  // Next-state values
  logic [2:0]  ctrl_d;
  logic [31:0] load_d;
  logic [31:0] count_d;
  logic [15:0] presc_d;
  logic        exp_d;
  logic [31:0] rdata_d;
  logic        rd_pend_d;

  // Decoded bus strobes
  logic        wr;
  logic        rd;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_count;
  logic        wr_status;
  logic        rd_status;

  // Timer events
  logic        en;
  logic        tick;
  logic        exp_set;
  logic        exp_clr;

  assign en = ctrl_q[CTRL_EN];

  always_comb begin
    wr        = sel && (we == 4'b1111);
    rd        = sel && re;
    wr_ctrl   = wr && (addr == ADDR_CTRL);
    wr_load   = wr && (addr == ADDR_LOAD);
    wr_count  = wr && (addr == ADDR_COUNT);
    wr_status = wr && (addr == ADDR_STATUS);
    rd_status = rd && (addr == ADDR_STATUS);
    tick      = en && (presc_q == PS_MAX);
  end

  // Prescaler: free-runs while enabled, parked at 0 otherwise. A COUNT write
  // restarts it so the freshly loaded value gets a full tick period.
  always_comb begin
    presc_d = presc_q + 16'd1;
    if (wr_count) begin
      presc_d = '0;
    end else if (wr_ctrl && !wdata[CTRL_EN]) begin
      presc_d = '0;
    end else if (!en) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end
  end

  // Counter and expiry. A COUNT write suppresses the coincident tick
  // entirely, including its expiry. The reload uses load_q, i.e. the LOAD
  // value from before any same-edge LOAD write.
  always_comb begin
    count_d = count_q;
    exp_set = 1'b0;
    if (wr_count) begin
      count_d = wdata;
    end else if (tick) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else if (count_q == 32'd1) begin
        exp_set = 1'b1;
        count_d = ctrl_q[CTRL_RELOAD] ? load_q : 32'd0;
      end
    end
  end

  // EXP is sticky; a set on the same edge as a clear wins so an expiry
  // can never be lost to a racing acknowledge.
  always_comb begin
    exp_clr = rd_status || (wr_status && wdata[0]);
    exp_d   = exp_q;
    if (exp_set) begin
      exp_d = 1'b1;
    end else if (exp_clr) begin
      exp_d = 1'b0;
    end
  end

  // Plain register writes
  always_comb begin
    ctrl_d = ctrl_q;
    load_d = load_q;
    if (wr_ctrl) begin
      ctrl_d = wdata[2:0];
    end
    if (wr_load) begin
      load_d = wdata;
    end
  end

  // Read path samples current (pre-write) register contents.
  always_comb begin
    rdata_d   = rdata_q;
    rd_pend_d = rd;
    if (rd) begin
      unique case (addr)
        ADDR_CTRL:   rdata_d = {29'd0, ctrl_q};
        ADDR_LOAD:   rdata_d = load_q;
        ADDR_COUNT:  rdata_d = count_q;
        ADDR_STATUS: rdata_d = {31'd0, exp_q};
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      presc_q   <= '0;
      exp_q     <= 1'b0;
      rdata_q   <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      exp_q     <= exp_d;
      rdata_q   <= rdata_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Read data is only presented in the cycle following a read. It is also
  // forced to 0 while reset is held, so a read issued just before reset
  // asserts never delivers stale data.
  assign rdata = (rd_pend_q && reset) ? rdata_q : 32'd0;

  assign irq = exp_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_mmio_timer.sv
module tb_mmio_timer;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_LOAD   = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        re;
  logic [31:0] rdata;
  logic        irq;

  int pass_cnt;
  int total_cnt;

  mmio_timer #(.PRESCALE(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .sel   (sel),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .re    (re),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        sel;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  // Table builders: expected values are those seen just after the cycle's closing edge.
  task automatic add(input logic r, input logic s, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] w, input logic rd, input logic [31:0] er, input logic ei);
    vec_t v;
    v.rst_n = r; v.sel = s; v.addr = a; v.wdata = d; v.we = w; v.re = rd;
    v.exp_rdata = er; v.exp_irq = ei;
    tbl.push_back(v);
  endtask

  task automatic add_w(input logic [1:0] a, input logic [31:0] d, input logic ei);
    add(1'b1, 1'b1, a, d, 4'hF, 1'b0, 32'd0, ei);
  endtask

  task automatic add_r(input logic [1:0] a, input logic [31:0] er, input logic ei);
    add(1'b1, 1'b1, a, 32'd0, 4'h0, 1'b1, er, ei);
  endtask

  task automatic add_i(input int n, input logic ei);
    for (int k = 0; k < n; k++) add(1'b1, 1'b0, 2'd0, 32'd0, 4'h0, 1'b0, 32'd0, ei);
  endtask

  // Drive one cycle of bus inputs, then move just past the closing edge.
  task automatic cyc(input logic r, input logic s, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] w, input logic rd);
    rst_n = r; sel = s; addr = a; wdata = d; we = w; re = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 2'd0, 32'd0, 4'h0, 1'b0);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d, 4'hF, 1'b0);
  endtask

  task automatic rd_reg(input logic [1:0] a);
    cyc(1'b1, 1'b1, a, 32'd0, 4'h0, 1'b1);
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0; sel = 1'b0; addr = 2'd0; wdata = 32'd0; we = 4'h0; re = 1'b0;

    // ---- reset state, byte-enable and select qualification ----
    add(1'b0, 1'b0, A_CTRL, 32'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    add(1'b0, 1'b1, A_LOAD, 32'd0, 4'h0, 1'b1, 32'd0, 1'b0);   // read during reset ignored
    add_i(1, 1'b0);
    add_r(A_CTRL, 32'd0, 1'b0);
    add_r(A_LOAD, 32'd0, 1'b0);
    add_r(A_COUNT, 32'd0, 1'b0);
    add_r(A_STATUS, 32'd0, 1'b0);
    add_w(A_LOAD, 32'd3, 1'b0);
    add_r(A_LOAD, 32'd3, 1'b0);
    add(1'b1, 1'b1, A_LOAD, 32'hAAAA_5555, 4'b0011, 1'b0, 32'd0, 1'b0);  // partial write
    add_r(A_LOAD, 32'd3, 1'b0);
    add(1'b1, 1'b0, A_LOAD, 32'd77, 4'hF, 1'b0, 32'd0, 1'b0);           // sel=0 write
    add(1'b1, 1'b0, A_LOAD, 32'd0, 4'h0, 1'b1, 32'd0, 1'b0);            // sel=0 read
    add_r(A_LOAD, 32'd3, 1'b0);
    add_w(A_CTRL, 32'hFFFF_FFF8, 1'b0);
    add_r(A_CTRL, 32'd0, 1'b0);
    add_w(A_CTRL, 32'hFFFF_FFF6, 1'b0);
    add_r(A_CTRL, 32'd6, 1'b0);
    add_w(A_CTRL, 32'd0, 1'b0);

    // ---- one-shot countdown: LOAD=3, COUNT=3, CTRL=EN ----
    add_w(A_COUNT, 32'd3, 1'b0);
    add_w(A_CTRL, 32'd1, 1'b0);             // E0
    add_i(3, 1'b0);                         // E1..E3
    add_r(A_COUNT, 32'd3, 1'b0);            // E4 tick: 3->2, read sees 3
    add_r(A_COUNT, 32'd2, 1'b0);            // E5
    add_i(2, 1'b0);                         // E6, E7
    add_r(A_COUNT, 32'd2, 1'b0);            // E8 tick: 2->1
    add_r(A_COUNT, 32'd1, 1'b0);            // E9
    add_r(A_STATUS, 32'd0, 1'b0);           // E10
    add_i(2, 1'b0);                         // E11, E12 tick: expire
    add_r(A_COUNT, 32'd0, 1'b0);            // E13
    add_r(A_STATUS, 32'd1, 1'b0);           // E14 read clears EXP
    add_r(A_STATUS, 32'd0, 1'b0);           // E15
    add_i(5, 1'b0);                         // E16..E20, ticks at 16 and 20 hold at 0
    add_r(A_COUNT, 32'd0, 1'b0);
    add_r(A_STATUS, 32'd0, 1'b0);           // no re-expiry
    add_w(A_CTRL, 32'd0, 1'b0);

    // ---- reload with interrupt: CTRL=EN|RELOAD|IRQ_EN ----
    add_w(A_COUNT, 32'd3, 1'b0);
    add_w(A_CTRL, 32'd7, 1'b0);             // F0
    add_i(8, 1'b0);                         // F1..F8
    add_r(A_COUNT, 32'd1, 1'b0);            // F9
    add_i(2, 1'b0);                         // F10, F11
    add_i(1, 1'b1);                         // F12 expire -> irq
    add_r(A_COUNT, 32'd3, 1'b1);            // F13 reloaded
    add_r(A_STATUS, 32'd1, 1'b0);           // F14 read clears, irq drops
    add_r(A_STATUS, 32'd0, 1'b0);           // F15
    add_i(8, 1'b0);                         // F16..F23
    add_w(A_LOAD, 32'd9, 1'b1);             // F24 expire + LOAD write
    add_r(A_COUNT, 32'd3, 1'b1);            // reload used old LOAD
    add_r(A_LOAD, 32'd9, 1'b1);
    add_w(A_STATUS, 32'd2, 1'b1);           // wdata[0]=0 does not clear

    // ---- reset mid-countdown with irq high ----
    add(1'b0, 1'b1, A_CTRL, 32'd7, 4'hF, 1'b1, 32'd0, 1'b0);
    add_r(A_CTRL, 32'd0, 1'b0);
    add_r(A_LOAD, 32'd0, 1'b0);
    add_r(A_COUNT, 32'd0, 1'b0);
    add_r(A_STATUS, 32'd0, 1'b0);
    add_w(A_COUNT, 32'd1, 1'b0);
    add_i(6, 1'b0);
    add_r(A_STATUS, 32'd0, 1'b0);           // no tick while EN=0
    add_r(A_COUNT, 32'd1, 1'b0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst_n, tbl[i].sel, tbl[i].addr, tbl[i].wdata, tbl[i].we, tbl[i].re);
      chk($sformatf("vec%0d rdata", i), rdata, tbl[i].exp_rdata);
      chk($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
    end

    // ---- STATUS read on the expiring edge: set wins ----
    cyc(1'b0, 1'b0, 2'd0, 32'd0, 4'h0, 1'b0);
    wr_reg(A_COUNT, 32'd1);
    wr_reg(A_CTRL, 32'd5);                  // EN|IRQ_EN, no reload
    idle(3);
    rd_reg(A_STATUS);                       // coincides with 1->0 expiry
    chk("race rdata", rdata, 32'd0);
    chk("race irq", {31'd0, irq}, 32'd1);
    wr_reg(A_STATUS, 32'd0);
    chk("status w0 irq", {31'd0, irq}, 32'd1);
    cyc(1'b1, 1'b1, A_STATUS, 32'd1, 4'b0001, 1'b0);
    chk("status partial irq", {31'd0, irq}, 32'd1);
    wr_reg(A_STATUS, 32'd1);
    chk("status w1 irq", {31'd0, irq}, 32'd0);
    rd_reg(A_STATUS);
    chk("status after clr", rdata, 32'd0);

    // ---- COUNT write coincident with a tick at COUNT=1 ----
    cyc(1'b0, 1'b0, 2'd0, 32'd0, 4'h0, 1'b0);
    wr_reg(A_COUNT, 32'd1);
    wr_reg(A_CTRL, 32'd1);                  // E0
    idle(3);
    wr_reg(A_COUNT, 32'd5);                 // E4, tick suppressed
    rd_reg(A_COUNT);
    chk("cwr count", rdata, 32'd5);
    rd_reg(A_STATUS);
    chk("cwr exp", rdata, 32'd0);
    idle(2);                                // E7, E8 tick 5->4
    rd_reg(A_COUNT);                        // E9
    chk("cwr next tick", rdata, 32'd4);
    wr_reg(A_COUNT, 32'd5);                 // E10, prescaler restarts
    idle(2);                                // E11, E12
    rd_reg(A_COUNT);                        // E13
    chk("presc restart", rdata, 32'd5);
    idle(1);                                // E14 tick
    rd_reg(A_COUNT);
    chk("presc tick", rdata, 32'd4);

    // ---- read and write on the same edge ----
    wr_reg(A_CTRL, 32'd0);
    wr_reg(A_LOAD, 32'h11);
    cyc(1'b1, 1'b1, A_LOAD, 32'h22, 4'hF, 1'b1);
    chk("rw pre value", rdata, 32'h11);
    rd_reg(A_LOAD);
    chk("rw post value", rdata, 32'h22);
    idle(1);
    chk("idle rdata", rdata, 32'd0);

    // ---- read issued just before reset returns 0 ----
    rd_reg(A_LOAD);
    chk("pre-rst read", rdata, 32'h22);
    rst_n = 1'b0; sel = 1'b0; re = 1'b0; we = 4'h0;
    #1;
    chk("read under rst", rdata, 32'd0);
    @(posedge clk);
    #1;
    chk("after rst rdata", rdata, 32'd0);
    rst_n = 1'b1;
    rd_reg(A_LOAD);
    chk("load after rst", rdata, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
